// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg
//   Shared types and helpers for the bit-serial transmitter.
//   - state_t : FSM state encoding (ST_IDLE, ST_SHIFT, ST_PARITY)
//   - clog2   : bit width needed to hold values 0..value-1 (minimum 1)
// ----------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// ----------------------------------------------------------------------------
// piso_serializer_if
//   Bundles the parallel handshake, the shift tick and the serial outputs.
//   master : the word source / serial sink (drives p_valid, p_data, bit_en)
//   slave  : the serializer (drives p_ready, s_out, s_valid, s_first,
//            s_last, busy)
// ----------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int WIDTH = 16
);
    logic             p_valid;
    logic [WIDTH-1:0] p_data;
    logic             p_ready;
    logic             bit_en;
    logic             s_out;
    logic             s_valid;
    logic             s_first;
    logic             s_last;
    logic             busy;

    modport master (
        output p_valid, p_data, bit_en,
        input  p_ready, s_out, s_valid, s_first, s_last, busy
    );

    modport slave (
        input  p_valid, p_data, bit_en,
        output p_ready, s_out, s_valid, s_first, s_last, busy
    );
endinterface

// File: rtl/ser_bit_ctr.sv
// ----------------------------------------------------------------------------
// ser_bit_ctr
//   Down-counter tracking the remaining bits of a frame.
//   clk      in   clock
//   reset    in   synchronous, active-high; clears the count
//   ld_i     in   load ld_val_i (has priority over dec_i)
//   ld_val_i in   value to load
//   dec_i    in   decrement by one
//   cnt_o    out  current count
//   zero_o   out  count is zero
// ----------------------------------------------------------------------------
module ser_bit_ctr #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ld_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. Takes a WIDTH-bit word on a
//   valid/ready handshake and sends it MSB first, one bit per bit_en tick,
//   with first/last framing strobes. Back-to-back words reload on the last
//   bit's edge so the serial stream has no gap.
//
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high; aborts any frame in flight
//   sif    slave modport of piso_serializer_if:
//            p_valid/p_data/p_ready  word handshake
//            bit_en                  shift tick
//            s_out/s_valid           serial bit and its qualifier
//            s_first/s_last          frame strobes
//            busy                    frame in progress
//
//   Optional build macro SER_PARITY_EN: appends an even-parity bit after
//   data bit 0, making the frame WIDTH+1 bits long.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no frame; ready for a word
//   ST_SHIFT  | sending data bits, sr MSB on s_out, cnt = bits left - 1
//   ST_PARITY | sending the parity bit (SER_PARITY_EN builds only)
// ----------------------------------------------------------------------------
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    piso_serializer_if.slave sif
);
    localparam int               CNT_W   = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             ctr_ld;
    logic             ctr_dec;
    logic             ctr_zero;
    logic [CNT_W-1:0] cnt;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par_q;
    logic             par_d;
`endif

    ser_bit_ctr #(
        .CNT_W (CNT_W)
    ) u_bit_ctr (
        .clk      (clk),
        .reset    (reset),
        .ld_i     (ctr_ld),
        .ld_val_i (CNT_TOP),
        .dec_i    (ctr_dec),
        .cnt_o    (cnt),
        .zero_o   (ctr_zero)
    );

    // Outputs: s_out comes straight from the register; everything else
    // decodes state, count and bit_en so p_ready can rise on the last bit.
    always_comb begin
        sif.p_ready = 1'b0;
        sif.busy    = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_first = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_out   = sr_q[WIDTH-1];
        case (state_q)
            ST_IDLE: begin
                sif.p_ready = 1'b1;
            end
            ST_SHIFT: begin
                sif.busy    = 1'b1;
                sif.s_valid = sif.bit_en;
                sif.s_first = sif.bit_en & (cnt == CNT_TOP);
`ifndef SER_PARITY_EN
                sif.s_last  = sif.bit_en & ctr_zero;
                sif.p_ready = sif.bit_en & ctr_zero;
`endif
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                sif.busy    = 1'b1;
                sif.s_out   = par_q;
                sif.s_valid = sif.bit_en;
                sif.s_last  = sif.bit_en;
                sif.p_ready = sif.bit_en;
            end
`endif
            default: begin
            end
        endcase
    end

    assign accept = sif.p_valid & sif.p_ready;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        ctr_ld  = 1'b0;
        ctr_dec = 1'b0;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                if (sif.bit_en) begin
                    sr_d = {sr_q[WIDTH-2:0], 1'b0};
                    if (!ctr_zero) begin
                        ctr_dec = 1'b1;
                    end else begin
`ifdef SER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
                if (sif.bit_en) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
            end
        endcase

        // A new word wins over the end-of-frame transition: this is the
        // zero-gap reload when p_ready rose on the last bit.
        if (accept) begin
            state_d = ST_SHIFT;
            sr_d    = sif.p_data;
            ctr_ld  = 1'b1;
`ifdef SER_PARITY_EN
            par_d   = ^sif.p_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
    localparam int WIDTH = 16;
`ifdef SER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference: the bits still to be sent for the current frame, front first.
    logic exp_bits[$];

    piso_serializer_if #(.WIDTH(WIDTH)) sif ();

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] w;
        w = d;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exp_bits.push_back(w[i]);
        end
`ifdef SER_PARITY_EN
        exp_bits.push_back(^w);
`endif
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic en, input logic r);
        logic busy_e;
        logic rdy_e;
        logic out_e;
        int   n;
        sif.p_valid = v;
        sif.p_data  = d;
        sif.bit_en  = en;
        reset       = r;
        @(negedge clk);
        n      = exp_bits.size();
        busy_e = (n != 0);
        rdy_e  = (n == 0) || (en && n == 1);
        out_e  = (n != 0) ? exp_bits[0] : 1'b0;
        chk("busy",    32'(sif.busy),    32'(busy_e));
        chk("p_ready", 32'(sif.p_ready), 32'(rdy_e));
        chk("s_valid", 32'(sif.s_valid), 32'(busy_e && en));
        chk("s_first", 32'(sif.s_first), 32'(busy_e && en && n == FL));
        chk("s_last",  32'(sif.s_last),  32'(busy_e && en && n == 1));
        chk("s_out",   32'(sif.s_out),   32'(out_e));
        if (r) begin
            exp_bits.delete();
        end else begin
            if (busy_e && en) begin
                void'(exp_bits.pop_front());
            end
            if (rdy_e && v) begin
                push_frame(d);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        sif.p_valid = 1'b0;
        sif.p_data  = '0;
        sif.bit_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Plain frame, bit_en held high.
        step(1'b1, 16'hA5C3, 1'b1, 1'b0);
        idle_steps(FL + 2);

        // Back-to-back words with p_valid held high.
        step(1'b1, 16'h8001, 1'b1, 1'b0);
        for (int i = 0; i < FL; i++) begin
            step(1'b1, 16'hFFFF, 1'b1, 1'b0);
        end
        idle_steps(FL + 2);

        // bit_en toggling: frame takes twice as long and holds between ticks.
        step(1'b1, 16'h00FF, 1'b1, 1'b0);
        for (int i = 0; i < 2 * FL + 2; i++) begin
            step(1'b0, '0, (i % 2) == 0, 1'b0);
        end

        // Reset in mid-frame, then a clean frame.
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        idle_steps(5);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h0F0F, 1'b1, 1'b0);
        idle_steps(FL + 1);

        // Parity reference words (plain frames when parity is built out).
        step(1'b1, 16'h0007, 1'b1, 1'b0);
        idle_steps(FL + 1);
        step(1'b1, 16'h0003, 1'b1, 1'b0);
        idle_steps(FL + 1);

        // p_data churning while busy: only the word presented at p_ready counts.
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        for (int i = 0; i < FL + 3; i++) begin
            step(1'b1, WIDTH'($urandom), 1'b1, 1'b0);
        end
        idle_steps(2 * FL + 2);

        // Random traffic with sparse bit_en gaps and rare resets.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1,
                 WIDTH'($urandom),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);
        end
        idle_steps(2 * FL + 2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
